// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter
//   Round-robin arbiter sharing a single Wishbone slave port between
//   NUM_MASTERS masters. A grant is held for as long as the granted master
//   keeps cyc high, so bursts stay atomic. A watchdog aborts slave transfers
//   that stall for TIMEOUT strobe cycles and returns err to the requester.
//
// Ports
//   wb_clk_i, wb_rst_i      clock, synchronous active-high reset
//   wbm_*_i                 per-master request buses, master n at slice n
//   wbm_dat_o               slave read data broadcast to every master slot
//   wbm_ack/err/rty_o       terminations, routed to the granted master only
//   wbs_*_o                 muxed request towards the slave
//   wbs_dat/ack/err/rty_i   slave response
//   grant_o                 one-hot current grant (status)
//   timeout_o               one-cycle pulse when the watchdog aborts

module wb_rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic [AW*NUM_MASTERS-1:0] wbm_adr_i,
  input  logic [DW*NUM_MASTERS-1:0] wbm_dat_i,
  input  logic [4*NUM_MASTERS-1:0]  wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]    wbm_we_i,
  input  logic [NUM_MASTERS-1:0]    wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]    wbm_stb_i,
  input  logic [3*NUM_MASTERS-1:0]  wbm_cti_i,
  input  logic [2*NUM_MASTERS-1:0]  wbm_bte_i,
  output logic [DW*NUM_MASTERS-1:0] wbm_dat_o,
  output logic [NUM_MASTERS-1:0]    wbm_ack_o,
  output logic [NUM_MASTERS-1:0]    wbm_err_o,
  output logic [NUM_MASTERS-1:0]    wbm_rty_o,
  output logic [AW-1:0]             wbs_adr_o,
  output logic [DW-1:0]             wbs_dat_o,
  output logic [3:0]                wbs_sel_o,
  output logic                      wbs_we_o,
  output logic                      wbs_cyc_o,
  output logic                      wbs_stb_o,
  output logic [2:0]                wbs_cti_o,
  output logic [1:0]                wbs_bte_o,
  input  logic [DW-1:0]             wbs_dat_i,
  input  logic                      wbs_ack_i,
  input  logic                      wbs_err_i,
  input  logic                      wbs_rty_i,
  output logic [NUM_MASTERS-1:0]    grant_o,
  output logic                      timeout_o
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_ABORT = 2'd2;

  logic [1:0]             r_state;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [IW-1:0]          r_last;
  logic [WW-1:0]          r_wdt;

  logic [IW-1:0]          w_next;
  logic                   w_any;
  logic                   w_cyc_g;
  logic                   w_stb_g;
  logic                   w_term;
  logic                   w_busy;
  int                     w_best;
  int                     w_dist;
  logic                   w_take;
  logic [AW-1:0]          w_adr;
  logic [DW-1:0]          w_dat;
  logic [3:0]             w_sel;
  logic                   w_we;
  logic [2:0]             w_cti;
  logic [1:0]             w_bte;

  function automatic logic [NUM_MASTERS-1:0] f_onehot(input logic [IW-1:0] idx);
    return NUM_MASTERS'(1'b1) << idx;
  endfunction

  assign w_any   = |wbm_cyc_i;
  assign w_cyc_g = |(wbm_cyc_i & r_grant);
  assign w_stb_g = |(wbm_stb_i & r_grant);
  assign w_term  = wbs_ack_i | wbs_err_i | wbs_rty_i;
  assign w_busy  = (r_state == ST_BUSY);

  // Round-robin winner: requester with the smallest distance above r_last.
  always_comb begin
    w_next = r_last;
    w_best = NUM_MASTERS;
    w_dist = 0;
    w_take = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      // Distance 0 is the master just after the last grant; the last
      // grantee itself is farthest away, giving it the lowest priority.
      w_dist = (i + NUM_MASTERS - 1 - int'(r_last)) % NUM_MASTERS;
      w_take = wbm_cyc_i[i] && (w_dist < w_best);
      w_next = w_take ? IW'(i) : w_next;
      w_best = w_take ? w_dist : w_best;
    end
  end

  // AND-OR mux of the granted master's request onto the slave side.
  always_comb begin
    w_adr = {AW{1'b0}};
    w_dat = {DW{1'b0}};
    w_sel = 4'b0000;
    w_we  = 1'b0;
    w_cti = 3'b000;
    w_bte = 2'b00;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      w_adr = w_adr | (wbm_adr_i[i*AW +: AW] & {AW{r_grant[i]}});
      w_dat = w_dat | (wbm_dat_i[i*DW +: DW] & {DW{r_grant[i]}});
      w_sel = w_sel | (wbm_sel_i[i*4 +: 4] & {4{r_grant[i]}});
      w_we  = w_we  | (wbm_we_i[i] & r_grant[i]);
      w_cti = w_cti | (wbm_cti_i[i*3 +: 3] & {3{r_grant[i]}});
      w_bte = w_bte | (wbm_bte_i[i*2 +: 2] & {2{r_grant[i]}});
    end
  end

  assign wbs_adr_o = w_adr;
  assign wbs_dat_o = w_dat;
  assign wbs_sel_o = w_sel;
  assign wbs_we_o  = w_we;
  assign wbs_cti_o = w_cti;
  assign wbs_bte_o = w_bte;
  assign wbs_cyc_o = w_busy & w_cyc_g;
  assign wbs_stb_o = w_busy & w_cyc_g & w_stb_g;

  assign wbm_dat_o = {NUM_MASTERS{wbs_dat_i}};
  assign wbm_ack_o = w_busy ? (r_grant & {NUM_MASTERS{wbs_ack_i}}) : {NUM_MASTERS{1'b0}};
  assign wbm_rty_o = w_busy ? (r_grant & {NUM_MASTERS{wbs_rty_i}}) : {NUM_MASTERS{1'b0}};
  // In ABORT the slave is disconnected, so err comes from the watchdog alone.
  assign wbm_err_o = (r_state == ST_ABORT) ? r_grant :
                     (w_busy ? (r_grant & {NUM_MASTERS{wbs_err_i}}) : {NUM_MASTERS{1'b0}});
  assign grant_o   = r_grant;
  assign timeout_o = (r_state == ST_ABORT);

  // Arbitration state, grant, last-grant pointer and watchdog counter.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= ST_IDLE;
      r_grant <= {NUM_MASTERS{1'b0}};
      r_last  <= IW'(NUM_MASTERS - 1);
      r_wdt   <= {WW{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_wdt <= {WW{1'b0}};
          if (w_any) begin
            r_state <= ST_BUSY;
            r_grant <= f_onehot(w_next);
            r_last  <= w_next;
          end
        end
        ST_BUSY: begin
          if (!w_cyc_g) begin
            // Hand over directly to the next requester, without an IDLE bubble.
            r_wdt <= {WW{1'b0}};
            if (w_any) begin
              r_grant <= f_onehot(w_next);
              r_last  <= w_next;
            end else begin
              r_state <= ST_IDLE;
              r_grant <= {NUM_MASTERS{1'b0}};
            end
          end else if ((TIMEOUT > 0) && w_stb_g && !w_term) begin
            if (r_wdt == WW'(TIMEOUT - 1)) begin
              r_state <= ST_ABORT;
              r_wdt   <= {WW{1'b0}};
            end else begin
              r_wdt <= r_wdt + WW'(1);
            end
          end else begin
            r_wdt <= {WW{1'b0}};
          end
        end
        ST_ABORT: begin
          r_wdt <= {WW{1'b0}};
          if (w_cyc_g) begin
            r_state <= ST_BUSY;
          end else if (w_any) begin
            r_state <= ST_BUSY;
            r_grant <= f_onehot(w_next);
            r_last  <= w_next;
          end else begin
            r_state <= ST_IDLE;
            r_grant <= {NUM_MASTERS{1'b0}};
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= {NUM_MASTERS{1'b0}};
          r_wdt   <= {WW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter
//   Self-checking bench for wb_rr_arbiter with three masters and an
//   eight-cycle watchdog. Directed scenario tasks check fixed expectations;
//   a randomized run checks every cycle against a behavioural model that
//   tracks only the owner, the last grantee and a stall count.

module tb_wb_rr_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [N*AW-1:0]   adr;
  logic [N*DW-1:0]   mdat;
  logic [4*N-1:0]    sel;
  logic [N-1:0]      we, cyc, stb;
  logic [3*N-1:0]    cti;
  logic [2*N-1:0]    bte;
  logic [N*DW-1:0]   wbm_dat_o;
  logic [N-1:0]      wbm_ack_o, wbm_err_o, wbm_rty_o, grant_o;
  logic [AW-1:0]     wbs_adr_o;
  logic [DW-1:0]     wbs_dat_o;
  logic [3:0]        wbs_sel_o;
  logic              wbs_we_o, wbs_cyc_o, wbs_stb_o, timeout_o;
  logic [2:0]        wbs_cti_o;
  logic [1:0]        wbs_bte_o;
  logic [DW-1:0]     sdat;
  logic              sack, serr, srty;

  wb_rr_arbiter #(.NUM_MASTERS(N), .DW(DW), .AW(AW), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbm_adr_i(adr), .wbm_dat_i(mdat), .wbm_sel_i(sel), .wbm_we_i(we),
    .wbm_cyc_i(cyc), .wbm_stb_i(stb), .wbm_cti_i(cti), .wbm_bte_i(bte),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
    .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
    .wbs_we_o(wbs_we_o), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
    .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
    .wbs_dat_i(sdat), .wbs_ack_i(sack), .wbs_err_i(serr), .wbs_rty_i(srty),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: owner index (-1 = none), abort flag, last grantee, stall count.
  int   m_owner = -1;
  int   m_last  = N - 1;
  int   m_wdt   = 0;
  bit   m_abort = 1'b0;
  int   m_win;
  int   m_sel;

  function automatic int winner(input int last, input logic [N-1:0] req);
    for (int k = 1; k <= N; k++) begin
      if (req[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  always @* m_win = winner(m_last, cyc);

  always @(posedge clk) begin
    if (rst) begin
      m_owner <= -1; m_abort <= 1'b0; m_last <= N - 1; m_wdt <= 0;
    end else if (m_owner < 0) begin
      if (m_win >= 0) begin m_owner <= m_win; m_last <= m_win; end
    end else if (m_abort || !cyc[m_owner]) begin
      m_abort <= 1'b0;
      m_wdt   <= 0;
      if (!cyc[m_owner]) begin
        if (m_win >= 0) begin m_owner <= m_win; m_last <= m_win; end
        else m_owner <= -1;
      end
    end else if (stb[m_owner] && !(sack || serr || srty)) begin
      if (m_wdt + 1 == TO) begin m_abort <= 1'b1; m_wdt <= 0; end
      else m_wdt <= m_wdt + 1;
    end else begin
      m_wdt <= 0;
    end
  end

  logic [N-1:0] e_grant, e_ack, e_err, e_rty;
  logic         e_busy, e_cyc, e_stb, e_to;
  logic [73:0]  e_bus;
  logic [14:0]  e_ctl, o_ctl;
  logic [73:0]  o_bus;

  always @* begin
    m_sel   = (m_owner < 0) ? 0 : m_owner;
    e_busy  = (m_owner >= 0) && !m_abort;
    e_grant = (m_owner >= 0) ? (3'b001 << m_sel) : 3'b000;
    e_cyc   = e_busy && cyc[m_sel];
    e_stb   = e_cyc && stb[m_sel];
    e_ack   = e_busy ? ({2'b00, sack} << m_sel) : 3'b000;
    e_rty   = e_busy ? ({2'b00, srty} << m_sel) : 3'b000;
    e_err   = m_abort ? e_grant : (e_busy ? ({2'b00, serr} << m_sel) : 3'b000);
    e_to    = m_abort;
    e_ctl   = {e_grant, e_cyc, e_stb, e_ack, e_err, e_rty, e_to};
    e_bus   = {adr[m_sel*AW +: AW], mdat[m_sel*DW +: DW], sel[m_sel*4 +: 4],
               we[m_sel], cti[m_sel*3 +: 3], bte[m_sel*2 +: 2]};
  end

  assign o_ctl = {grant_o, wbs_cyc_o, wbs_stb_o, wbm_ack_o, wbm_err_o, wbm_rty_o, timeout_o};
  assign o_bus = {wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cti_o, wbs_bte_o};

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cyc = '0; stb = '0; we = '0; sack = 1'b0; serr = 1'b0; srty = 1'b0;
    adr = '0; mdat = '0; sel = '0; cti = '0; bte = '0; sdat = '0;
    tick(); tick();
    @(negedge clk);
    total++;
    if (o_ctl !== 15'd0) begin bad++; $display("FAIL reset_ctl got=%h want=0", o_ctl); end
    total++;
    if (o_ctl !== e_ctl) begin bad++; $display("FAIL reset_model got=%h want=%h", o_ctl, e_ctl); end
    tick(); rst = 1'b0;
  endtask

  task automatic test_two_masters();
    tick();
    adr[0 +: AW] = 32'h100; adr[AW +: AW] = 32'h200; cyc = 3'b011; stb = 3'b011;
    @(negedge clk);
    total++;
    if (grant_o !== 3'b000) begin bad++; $display("FAIL two_latency got=%b want=000", grant_o); end
    tick(); sack = 1'b1;
    @(negedge clk);
    total++;
    if ({grant_o, wbs_adr_o, wbm_ack_o} !== {3'b001, 32'h100, 3'b001}) begin
      bad++; $display("FAIL two_first got=%b/%h/%b want=001/100/001", grant_o, wbs_adr_o, wbm_ack_o);
    end
    tick(); sack = 1'b0; cyc = 3'b010; stb = 3'b010;
    @(negedge clk);
    total++;
    if ({grant_o, wbs_cyc_o} !== 4'b0010) begin bad++; $display("FAIL two_drop got=%b/%b want=001/0", grant_o, wbs_cyc_o); end
    tick();
    @(negedge clk);
    total++;
    if ({grant_o, wbs_adr_o} !== {3'b010, 32'h200}) begin
      bad++; $display("FAIL two_second got=%b/%h want=010/200", grant_o, wbs_adr_o);
    end
    tick(); sack = 1'b1;
    @(negedge clk);
    total++;
    if (wbm_ack_o !== 3'b010) begin bad++; $display("FAIL two_ack1 got=%b want=010", wbm_ack_o); end
    tick(); sack = 1'b0; cyc = '0; stb = '0;
    tick(); tick();
  endtask

  task automatic test_burst();
    int acks0 = 0;
    int acks1 = 0;
    tick();
    adr[0 +: AW] = 32'h1000; cti[0 +: 3] = 3'b010; cyc = 3'b011; stb = 3'b011;
    tick();
    for (int b = 0; b < 4; b++) begin
      adr[0 +: AW] = 32'h1000 + 32'(4 * b);
      cti[0 +: 3]  = (b == 3) ? 3'b111 : 3'b010;
      sack = 1'b1;
      @(negedge clk);
      if (wbm_ack_o[0]) acks0++;
      if (wbm_ack_o[1]) acks1++;
      total++;
      if ({grant_o, wbs_adr_o} !== {3'b001, 32'h1000 + 32'(4 * b)}) begin
        bad++; $display("FAIL burst_beat%0d got=%b/%h want=001/%h", b, grant_o, wbs_adr_o, 32'h1000 + 32'(4 * b));
      end
      tick();
    end
    sack = 1'b0; cyc = 3'b010; stb = 3'b010; cti = '0;
    @(negedge clk);
    total++;
    if (grant_o !== 3'b001) begin bad++; $display("FAIL burst_hold got=%b want=001", grant_o); end
    total++;
    if (acks0 !== 4) begin bad++; $display("FAIL burst_acks_m0 got=%0d want=4", acks0); end
    total++;
    if (acks1 !== 0) begin bad++; $display("FAIL burst_acks_m1 got=%0d want=0", acks1); end
    tick();
    @(negedge clk);
    total++;
    if (grant_o !== 3'b010) begin bad++; $display("FAIL burst_handoff got=%b want=010", grant_o); end
    tick(); sack = 1'b1;
    tick(); sack = 1'b0; cyc = '0; stb = '0;
    tick(); tick();
  endtask

  task automatic test_three_rr();
    logic [N-1:0] eg;
    rst = 1'b1; cyc = 3'b111; stb = 3'b111;
    tick(); rst = 1'b0;
    tick();
    for (int g = 0; g < 6; g++) begin
      eg = 3'b001 << (g % 3);
      sack = 1'b1;
      @(negedge clk);
      total++;
      if ({grant_o, wbm_ack_o} !== {eg, eg}) begin
        bad++; $display("FAIL rr_grant%0d got=%b/%b want=%b", g, grant_o, wbm_ack_o, eg);
      end
      tick(); sack = 1'b0; cyc[g % 3] = 1'b0; stb[g % 3] = 1'b0;
      tick(); cyc[g % 3] = 1'b1; stb[g % 3] = 1'b1;
    end
    cyc = '0; stb = '0;
    tick(); tick();
  endtask

  task automatic test_timeout();
    tick();
    adr[AW +: AW] = 32'h300; cyc = 3'b010; stb = 3'b010; we = 3'b010;
    tick();
    for (int n = 1; n <= TO; n++) begin
      @(negedge clk);
      total++;
      if ({wbs_cyc_o, wbs_stb_o, timeout_o, wbm_err_o} !== 6'b110000) begin
        bad++; $display("FAIL wd_wait%0d got=%b want=110000", n, {wbs_cyc_o, wbs_stb_o, timeout_o, wbm_err_o});
      end
      tick();
    end
    @(negedge clk);
    total++;
    if ({wbs_cyc_o, wbs_stb_o, timeout_o, wbm_err_o} !== 6'b001010) begin
      bad++; $display("FAIL wd_abort got=%b want=001010", {wbs_cyc_o, wbs_stb_o, timeout_o, wbm_err_o});
    end
    tick();
    @(negedge clk);
    total++;
    if ({wbs_cyc_o, timeout_o, grant_o} !== 5'b10010) begin
      bad++; $display("FAIL wd_resume got=%b want=10010", {wbs_cyc_o, timeout_o, grant_o});
    end
    cyc = '0; stb = '0; we = '0;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    tick();
    cyc = 3'b010; stb = 3'b010; cti[3 +: 3] = 3'b010;
    tick(); sack = 1'b1;
    tick(); tick();
    rst = 1'b1; cyc = 3'b111; stb = 3'b111;
    tick(); rst = 1'b0;
    @(negedge clk);
    total++;
    if ({wbs_cyc_o, grant_o, wbm_ack_o, wbm_err_o} !== 10'd0) begin
      bad++; $display("FAIL rstmid_drop got=%b want=0", {wbs_cyc_o, grant_o, wbm_ack_o, wbm_err_o});
    end
    tick();
    @(negedge clk);
    total++;
    if ({grant_o, wbs_cyc_o} !== 4'b0011) begin bad++; $display("FAIL rstmid_first got=%b/%b want=001/1", grant_o, wbs_cyc_o); end
    sack = 1'b0; cyc = '0; stb = '0; cti = '0;
    tick(); tick();
  endtask

  task automatic test_rty();
    tick();
    cyc = 3'b100; stb = 3'b100;
    tick(); srty = 1'b1;
    @(negedge clk);
    total++;
    if ({wbm_rty_o, grant_o} !== 6'b100100) begin bad++; $display("FAIL rty_route got=%b/%b want=100/100", wbm_rty_o, grant_o); end
    tick(); srty = 1'b0; cyc = 3'b101; stb = 3'b101;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      total++;
      if (grant_o !== 3'b100) begin bad++; $display("FAIL rty_hold%0d got=%b want=100", n, grant_o); end
      tick();
    end
    cyc = 3'b001; stb = 3'b001;
    tick();
    @(negedge clk);
    total++;
    if (grant_o !== 3'b001) begin bad++; $display("FAIL rty_next got=%b want=001", grant_o); end
    cyc = '0; stb = '0;
    tick(); tick();
  endtask

  task automatic test_random();
    bit quiet;
    for (int n = 0; n < 2000; n++) begin
      quiet = (((n / 64) % 4) == 3);
      rst   = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < N; i++) begin
        if (cyc[i]) cyc[i] = ($urandom_range(0, 7) != 0);
        else        cyc[i] = ($urandom_range(0, 2) == 0);
        stb[i] = cyc[i] && (quiet || ($urandom_range(0, 3) != 0));
      end
      adr  = {$urandom(), $urandom(), $urandom()};
      mdat = {$urandom(), $urandom(), $urandom()};
      sel  = 12'($urandom()); we = 3'($urandom()); cti = 9'($urandom()); bte = 6'($urandom());
      sdat = $urandom();
      sack = !quiet && ($urandom_range(0, 9) < 4);
      serr = !quiet && ($urandom_range(0, 19) == 0);
      srty = !quiet && ($urandom_range(0, 19) == 0);
      @(negedge clk);
      total++;
      if (o_ctl !== e_ctl) begin bad++; $display("FAIL rnd_ctl n=%0d got=%h want=%h", n, o_ctl, e_ctl); end
      if (e_busy) begin
        total++;
        if (o_bus !== e_bus) begin bad++; $display("FAIL rnd_bus n=%0d got=%h want=%h", n, o_bus, e_bus); end
      end
      total++;
      if (wbm_dat_o !== {N{sdat}}) begin bad++; $display("FAIL rnd_dat n=%0d got=%h want=%h", n, wbm_dat_o, {N{sdat}}); end
      tick();
    end
    rst = 1'b0; cyc = '0; stb = '0; sack = 1'b0; serr = 1'b0; srty = 1'b0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_two_masters();
    test_burst();
    test_three_rr();
    test_timeout();
    test_reset_mid();
    test_rty();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Shares one Wishbone slave port between NUM_MASTERS masters using round-robin arbitration.
- Sits between the per-core instruction/data buses and the single-master port of the system interconnect.
- Grant is held for the whole cycle (cyc high), so classic and incrementing bursts stay atomic.
- A watchdog terminates slave transfers that stall with an error to the requesting master.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (1..8)
- DW, 32, data width
- AW, 32, address width
- TIMEOUT, 255, cycles of unacknowledged stb before abort; 0 disables the watchdog

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous active-high reset
- wbm_adr_i  in  AW*NUM_MASTERS  master addresses; master n at [n*AW +: AW]
- wbm_dat_i  in  DW*NUM_MASTERS  master write data
- wbm_sel_i  in  4*NUM_MASTERS  byte selects
- wbm_we_i  in  NUM_MASTERS  write enables
- wbm_cyc_i  in  NUM_MASTERS  cycle / request
- wbm_stb_i  in  NUM_MASTERS  strobes
- wbm_cti_i  in  3*NUM_MASTERS  cycle type
- wbm_bte_i  in  2*NUM_MASTERS  burst type
- wbm_dat_o  out  DW*NUM_MASTERS  read data, slave data broadcast to every slot
- wbm_ack_o  out  NUM_MASTERS  ack, granted master only
- wbm_err_o  out  NUM_MASTERS  err, granted master only
- wbm_rty_o  out  NUM_MASTERS  rty, granted master only
- wbs_adr_o  out  AW  slave address
- wbs_dat_o  out  DW  slave write data
- wbs_sel_o  out  4  slave byte selects
- wbs_we_o  out  1  slave write enable
- wbs_cyc_o  out  1  slave cycle
- wbs_stb_o  out  1  slave strobe
- wbs_cti_o  out  3  slave cycle type
- wbs_bte_o  out  2  slave burst type
- wbs_dat_i  in  DW  slave read data
- wbs_ack_i  in  1  slave ack
- wbs_err_i  in  1  slave err
- wbs_rty_i  in  1  slave rty
- grant_o  out  NUM_MASTERS  one-hot current grant (status)
- timeout_o  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset: state IDLE, grant_o=0, last-grant pointer = NUM_MASTERS-1 (so master 0 wins first), watchdog counter=0. All wbm_ack/err/rty_o=0, wbs_cyc_o=0, wbs_stb_o=0, timeout_o=0. Reset mid-transfer drops wbs_cyc_o in the next cycle, with no ack/err emitted.
- Arbitration: the next grant is the first requesting master (cyc=1), searching upward from last-grant+1 with wrap-around. It is registered, so there is 1 cycle from a request in IDLE to wbs_cyc_o.
- State IDLE: grant_o=0 and wbs_cyc/stb=0. Any cyc goes to BUSY with the computed grant.
- State BUSY: wbs_* = the granted master's signals (combinational mux). wbs_ack/err/rty_i are routed only to the granted bit; all other bits are 0.
  - Granted cyc falls, other requests pending: grant moves to the next winner the following cycle, with no IDLE bubble.
  - Granted cyc falls, no other requests: go to IDLE.
  - Granted cyc held: grant is never preempted, whatever the cti value.
- last-grant pointer updates on every new grant.
- Watchdog (TIMEOUT>0):
  - Counter increments each BUSY cycle with wbs_stb_o=1 and no ack/err/rty. It clears on any termination, on stb low, or on grant change.
  - Counter reaching TIMEOUT forces state ABORT.
- State ABORT, lasting one cycle:
  - wbs_cyc_o=wbs_stb_o=0.
  - Granted wbm_err_o=1 and timeout_o=1.
  - Next state: BUSY with the same grant if its cyc is still high; otherwise re-arbitrate per BUSY rules.
  - A slave ack arriving in the ABORT cycle is ignored.
- Simultaneous wbs_ack_i and wbs_err_i: both are forwarded. Wishbone forbids this, and the arbiter does not resolve it.
- NUM_MASTERS=1: permanent round-robin to master 0, with only the 1-cycle grant latency.

Test Plan:
- Reset, then masters 0 and 1 both raise cyc/stb single reads with adr 0x100 and 0x200. Required: wbs_adr_o=0x100 first, grant_o=01. After m0 drops cyc, the next cycle shows grant_o=10 and wbs_adr_o=0x200.
- m0 runs a 4-beat incrementing burst (cti=010, last beat 111) while m1 requests throughout. Required: 4 acks reach m0 only, m1 sees ack=0, and grant_o stays 01 until m0 cyc falls.
- 3 masters all request continuously, each dropping cyc after one ack. Required: grant sequence 0,1,2,0,1,2.
- TIMEOUT=8, slave never acks m1's write. Required: on the 9th stb cycle, wbm_err_o[1]=1 and timeout_o=1 for one cycle, with wbs_cyc_o=0 in that cycle.
- wb_rst_i asserted mid-burst. Required: next cycle wbs_cyc_o=0, grant_o=0, no ack/err to any master. After release, master 0 wins first.
- Slave returns rty to m2. Required: wbm_rty_o=100 and grant held while m2 cyc stays high.
